esc_arm_sequencer: RTL and testbench
====================================

# esc_arm_sequencer

Supervisory controller between the current-control stage and the ESC PWM generator. It owns the ESC arming sequence, rate-limits throttle increases, and forces zero throttle on brake, disable, or a stale command stream. All motor commands reach the PWM generator only through this block.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency
- `TICK_HZ`, 1000, internal tick rate; one tick = 1 ms at defaults
- `ARM_TICKS`, 2000, ticks at zero throttle before the ESC counts as armed
- `RAMP_STEP`, 4, maximum output increase per tick
- `TIMEOUT_TICKS`, 100, ticks without `cmd_valid_i` in ARMED before FAULT
- `CMD_MAX`, 1000, command clamp ceiling; `CMD_MAX + RAMP_STEP` must be < 1024

- `c50m`, in, 1, system clock
- `reset_n`, in, 1, asynchronous active-low reset
- `enable_i`, in, 1, level; rider request to arm and run
- `brake_i`, in, 1, level; forces zero throttle
- `fault_clear_i`, in, 1, pulse; acknowledges a fault
- `cmd_valid_i`, in, 1, pulse; `cmd_i` is valid this cycle
- `cmd_i`, in, 10, requested duty from current control
- `motor_cmd_o`, out, 10, registered duty to the PWM generator
- `armed_o`, out, 1, high in ARMED
- `fault_o`, out, 1, high in FAULT
- `state_o`, out, 2, encoded current state, for debug probe

## Operation
- **Reset values:**
  - `motor_cmd_o` = 0, `armed_o` = 0, `fault_o` = 0, `state_o` = DISARMED.
  - Target, arm counter, watchdog counter and prescaler all cleared.
- **Tick:** the prescaler counts 0..CLK_HZ/TICK_HZ−1 and emits a one-cycle tick on wrap. It runs freely from reset.
- **DISARMED** (encoding 0):
  - Output 0.
  - `enable_i` & !`brake_i` → ARMING, arm counter cleared.
- **ARMING** (encoding 1):
  - Output 0.
  - Arm counter increments on each tick. When it reaches ARM_TICKS → ARMED, with target 0 and watchdog cleared.
  - !`enable_i` or `brake_i` → DISARMED. The count is discarded; re-arming restarts from 0.
- **ARMED** (encoding 2):
  - `cmd_valid_i` latches min(`cmd_i`, CMD_MAX) into target and clears the watchdog.
  - On each tick, output steps up toward target:
    - if target − out ≥ RAMP_STEP, out += RAMP_STEP;
    - else if target > out, out = target.
  - Decreases take effect the next cycle without waiting for a tick (unbounded down-slew).
  - `brake_i`: target and output = 0 next cycle. State stays ARMED and the watchdog keeps running.
  - !`enable_i` → DISARMED, output 0.
  - Watchdog increments on each tick. When it reaches TIMEOUT_TICKS → FAULT.
- **FAULT** (encoding 3):
  - Output 0, `fault_o` = 1.
  - Leaves only on `fault_clear_i` & !`enable_i` → DISARMED. A clear while `enable_i` = 1 is ignored.
- **Priority within ARMED, same cycle:** timeout > !enable > brake > cmd_valid.
  - `cmd_valid_i` on the tick where the watchdog would expire resets the watchdog; no fault occurs.
  - `brake_i` with `cmd_valid_i` drops the command and leaves target at 0.
- **Reset mid-operation:** asynchronous return to reset values. The output drops to 0 without waiting for a clock.

## Timing
- Next-state logic is single-cycle; every output is registered.
- `cmd_valid_i` → target updated at the next edge. The output reflects it at the first tick after that edge, moving by at most RAMP_STEP.
- Brake or disable → `motor_cmd_o` = 0 one cycle later.
- Arming takes ARM_TICKS ticks from ARMING entry; the first tick may be partial (0..1 tick of jitter).
- Full ramp from 0 to CMD_MAX takes ceil(CMD_MAX/RAMP_STEP) ticks: 250 ms at defaults.

## Structure
- **`motor_ctrl_pkg`:**
  - `esc_state_t` enum: DISARMED=0, ARMING=1, ARMED=2, FAULT=3.
  - `CMD_W` = 10.
  - Default `CMD_MAX`.
  - Shared with current control and the PWM generator.
- **Sub-module `tick_prescaler`:** parameters CLK_HZ and TICK_HZ; ports `c50m`, `reset_n`, `tick_o`.
- Everything else is one FSM with three counters, in a single module.

## Test plan
All scenarios use CLK_HZ=10_000, TICK_HZ=1000 (tick every 10 cycles), ARM_TICKS=5, TIMEOUT_TICKS=8.

1. **Arming:** `enable_i`=1 with commands every 3 ticks → `armed_o` rises after 5 ticks; `motor_cmd_o` stays 0 throughout ARMING.
2. **Ramp:** while armed, `cmd_i`=10 → output goes 4, 8, 10 on successive ticks. `cmd_i`=1023 → target clamps to 1000.
3. **Brake:** at output 200, assert `brake_i` → 0 in one cycle. A simultaneous `cmd_valid_i` with `cmd_i`=500 is ignored.
4. **Watchdog:** stop commands → FAULT after 8 ticks with output 0.
   - `fault_clear_i` while `enable_i`=1 → stays FAULT.
   - Clear with `enable_i`=0 → DISARMED.
5. **Abort and reset:**
   - Drop `enable_i` in ARMING at tick 3 → DISARMED; re-arm takes a full 5 ticks.
   - `reset_n` low mid-ramp → all outputs 0 asynchronously.

Source files
------------

// File: rtl/motor_ctrl_pkg.sv
// Shared motor-control types and constants, used by current control,
// the ESC arm sequencer and the PWM generator.
package motor_ctrl_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    ARMED    = 2'd2,
    FAULT    = 2'd3
  } esc_state_t;

  localparam int CMD_W        = 10;
  localparam int CMD_MAX_DFLT = 1000;

  function automatic logic [CMD_W-1:0] clamp_cmd(input logic [CMD_W-1:0] cmd,
                                                 input logic [CMD_W-1:0] ceiling);
    return (cmd > ceiling) ? ceiling : cmd;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every CLK_HZ/TICK_HZ clocks.
module tick_prescaler #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic c50m,
  input  logic reset_n,
  output logic tick_o
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  always_comb begin
    wrap  = (cnt_q == CNT_W'(DIV - 1));
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge c50m or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = wrap;

endmodule

// File: rtl/esc_arm_sequencer.sv
// Supervisory ESC controller: arming sequence, throttle rate limiting and
// forced-zero on brake, disable or a stale command stream.
module esc_arm_sequencer
  import motor_ctrl_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int TICK_HZ       = 1000,
  parameter int ARM_TICKS     = 2000,
  parameter int RAMP_STEP     = 4,
  parameter int TIMEOUT_TICKS = 100,
  parameter int CMD_MAX       = CMD_MAX_DFLT
) (
  input  logic             c50m,
  input  logic             reset_n,
  input  logic             enable_i,
  input  logic             brake_i,
  input  logic             fault_clear_i,
  input  logic             cmd_valid_i,
  input  logic [CMD_W-1:0] cmd_i,
  output logic [CMD_W-1:0] motor_cmd_o,
  output logic             armed_o,
  output logic             fault_o,
  output logic [1:0]       state_o
);

  localparam int ARM_W  = $clog2(ARM_TICKS + 1);
  localparam int WDOG_W = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [CMD_W-1:0]  CMD_CEIL  = CMD_W'(CMD_MAX);
  localparam logic [CMD_W-1:0]  STEP      = CMD_W'(RAMP_STEP);
  localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(ARM_TICKS - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_TICKS - 1);

  esc_state_t        state_q, state_d;
  logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [CMD_W-1:0]  target_q, target_d;
  logic [CMD_W-1:0]  out_q, out_d;
  logic              armed_q, armed_d;
  logic              fault_q, fault_d;
  logic              tick;
  logic              wdog_expire;

  tick_prescaler #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick (
    .c50m   (c50m),
    .reset_n(reset_n),
    .tick_o (tick)
  );

  always_ff @(posedge c50m or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= DISARMED;
      arm_cnt_q <= '0;
      wdog_q    <= '0;
      target_q  <= '0;
      out_q     <= '0;
      armed_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
      wdog_q    <= wdog_d;
      target_q  <= target_d;
      out_q     <= out_d;
      armed_q   <= armed_d;
      fault_q   <= fault_d;
    end
  end

  // A command arriving on the expiring tick counts as a refresh, so it beats the timeout.
  assign wdog_expire = tick && (wdog_q == WDOG_LAST) && !cmd_valid_i;

  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    wdog_d    = wdog_q;
    target_d  = target_q;
    case (state_q)
      DISARMED: begin
        arm_cnt_d = '0;
        wdog_d    = '0;
        target_d  = '0;
        if (enable_i && !brake_i) begin
          state_d = ARMING;
        end
      end
      ARMING: begin
        if (!enable_i || brake_i) begin
          state_d   = DISARMED;
          arm_cnt_d = '0;
        end else if (tick) begin
          if (arm_cnt_q == ARM_LAST) begin
            state_d   = ARMED;
            arm_cnt_d = '0;
            wdog_d    = '0;
            target_d  = '0;
          end else begin
            arm_cnt_d = arm_cnt_q + 1'b1;
          end
        end
      end
      ARMED: begin
        if (cmd_valid_i) begin
          wdog_d = '0;
        end else if (tick) begin
          wdog_d = wdog_q + 1'b1;
        end
        if (wdog_expire) begin
          state_d  = FAULT;
          wdog_d   = '0;
          target_d = '0;
        end else if (!enable_i) begin
          state_d  = DISARMED;
          wdog_d   = '0;
          target_d = '0;
        end else if (brake_i) begin
          target_d = '0;
        end else if (cmd_valid_i) begin
          target_d = clamp_cmd(cmd_i, CMD_CEIL);
        end
      end
      FAULT: begin
        if (fault_clear_i && !enable_i) begin
          state_d = DISARMED;
        end
      end
      default: state_d = DISARMED;
    endcase
  end

  // Rises are rate limited to one step per tick; falls follow the target immediately.
  always_comb begin
    armed_d = (state_d == ARMED);
    fault_d = (state_d == FAULT);
    out_d   = '0;
    if ((state_q == ARMED) && (state_d == ARMED) && !brake_i) begin
      out_d = out_q;
      if (target_q < out_q) begin
        out_d = target_q;
      end else if (tick && (target_q > out_q)) begin
        out_d = ((target_q - out_q) >= STEP) ? (out_q + STEP) : target_q;
      end
    end
  end

  assign motor_cmd_o = out_q;
  assign armed_o     = armed_q;
  assign fault_o     = fault_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_esc_arm_sequencer.sv
// Directed bench for esc_arm_sequencer with a 10-cycle tick, 5-tick arming
// and an 8-tick command watchdog.
module tb_esc_arm_sequencer;

  logic       c50m;
  logic       reset_n;
  logic       enable_i;
  logic       brake_i;
  logic       fault_clear_i;
  logic       cmd_valid_i;
  logic [9:0] cmd_i;
  logic [9:0] motor_cmd_o;
  logic       armed_o;
  logic       fault_o;
  logic [1:0] state_o;

  int total;
  int bad;
  int edges;

  esc_arm_sequencer #(
    .CLK_HZ       (10_000),
    .TICK_HZ      (1000),
    .ARM_TICKS    (5),
    .RAMP_STEP    (4),
    .TIMEOUT_TICKS(8),
    .CMD_MAX      (1000)
  ) dut (
    .c50m         (c50m),
    .reset_n      (reset_n),
    .enable_i     (enable_i),
    .brake_i      (brake_i),
    .fault_clear_i(fault_clear_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_i        (cmd_i),
    .motor_cmd_o  (motor_cmd_o),
    .armed_o      (armed_o),
    .fault_o      (fault_o),
    .state_o      (state_o)
  );

  initial c50m = 1'b0;
  always #5 c50m = ~c50m;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic clk(input int n);
    repeat (n) begin
      @(posedge c50m);
      edges++;
    end
    #1;
  endtask

  // Ticks are consumed on every 10th edge after reset release.
  task automatic next_tick();
    do clk(1); while (edges % 10 != 0);
  endtask

  task automatic send_cmd(input logic [9:0] value);
    cmd_valid_i = 1'b1;
    cmd_i       = value;
    clk(1);
    cmd_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable_i = 1'b0; brake_i = 1'b0; fault_clear_i = 1'b0;
    cmd_valid_i = 1'b0; cmd_i = '0;
    #22;
    total++; if (motor_cmd_o !== 10'd0) begin bad++; $display("[TB] FAIL reset_motor: got %0d expected 0", motor_cmd_o); end
    total++; if (armed_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_armed: got %0b expected 0", armed_o); end
    total++; if (fault_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_fault: got %0b expected 0", fault_o); end
    total++; if (state_o !== 2'd0) begin bad++; $display("[TB] FAIL reset_state: got %0d expected 0", state_o); end
    reset_n = 1'b1;
    edges   = 0;
  endtask

  task automatic test_arming();
    enable_i = 1'b1;
    clk(1);
    total++; if (state_o !== 2'd1) begin bad++; $display("[TB] FAIL arming_entry: got %0d expected 1", state_o); end
    for (int t = 1; t <= 4; t++) begin
      next_tick();
      if (t == 3) send_cmd(10'd300);
      total++; if (state_o !== 2'd1 || armed_o !== 1'b0) begin bad++; $display("[TB] FAIL arming_wait_t%0d: got state %0d armed %0b expected 1/0", t, state_o, armed_o); end
      total++; if (motor_cmd_o !== 10'd0) begin bad++; $display("[TB] FAIL arming_motor_t%0d: got %0d expected 0", t, motor_cmd_o); end
    end
    next_tick();
    total++; if (armed_o !== 1'b1 || state_o !== 2'd2) begin bad++; $display("[TB] FAIL arming_done: got armed %0b state %0d expected 1/2", armed_o, state_o); end
    total++; if (motor_cmd_o !== 10'd0) begin bad++; $display("[TB] FAIL arming_done_motor: got %0d expected 0", motor_cmd_o); end
  endtask

  task automatic test_ramp();
    logic [9:0] exp_seq [4];
    exp_seq[0] = 10'd4; exp_seq[1] = 10'd8; exp_seq[2] = 10'd10; exp_seq[3] = 10'd10;
    send_cmd(10'd10);
    for (int i = 0; i < 4; i++) begin
      next_tick();
      total++; if (motor_cmd_o !== exp_seq[i]) begin bad++; $display("[TB] FAIL ramp10_step%0d: got %0d expected %0d", i, motor_cmd_o, exp_seq[i]); end
    end
    send_cmd(10'd1023);
    next_tick();
    total++; if (motor_cmd_o !== 10'd14) begin bad++; $display("[TB] FAIL ramp_clamp_first: got %0d expected 14", motor_cmd_o); end
    for (int i = 0; i < 260; i++) begin
      if (i % 4 == 0) send_cmd(10'd1023);
      next_tick();
    end
    total++; if (motor_cmd_o !== 10'd1000) begin bad++; $display("[TB] FAIL ramp_clamp_ceiling: got %0d expected 1000", motor_cmd_o); end
    send_cmd(10'd200);
    total++; if (motor_cmd_o !== 10'd1000) begin bad++; $display("[TB] FAIL decrease_latency: got %0d expected 1000", motor_cmd_o); end
    clk(1);
    total++; if (motor_cmd_o !== 10'd200) begin bad++; $display("[TB] FAIL decrease_immediate: got %0d expected 200", motor_cmd_o); end
  endtask

  task automatic test_brake();
    brake_i = 1'b1;
    cmd_valid_i = 1'b1;
    cmd_i = 10'd500;
    clk(1);
    brake_i = 1'b0;
    cmd_valid_i = 1'b0;
    total++; if (motor_cmd_o !== 10'd0) begin bad++; $display("[TB] FAIL brake_zero: got %0d expected 0", motor_cmd_o); end
    total++; if (state_o !== 2'd2) begin bad++; $display("[TB] FAIL brake_state: got %0d expected 2", state_o); end
    next_tick();
    next_tick();
    total++; if (motor_cmd_o !== 10'd0) begin bad++; $display("[TB] FAIL brake_cmd_dropped: got %0d expected 0", motor_cmd_o); end
  endtask

  task automatic test_watchdog();
    send_cmd(10'd40);
    for (int t = 0; t < 7; t++) next_tick();
    total++; if (state_o !== 2'd2 || motor_cmd_o !== 10'd28) begin bad++; $display("[TB] FAIL wdog_pre: got state %0d motor %0d expected 2/28", state_o, motor_cmd_o); end
    while (edges % 10 != 9) clk(1);
    send_cmd(10'd40);
    total++; if (state_o !== 2'd2 || motor_cmd_o !== 10'd32) begin bad++; $display("[TB] FAIL wdog_refresh_on_expiry: got state %0d motor %0d expected 2/32", state_o, motor_cmd_o); end
    for (int t = 0; t < 7; t++) next_tick();
    total++; if (state_o !== 2'd2 || motor_cmd_o !== 10'd40) begin bad++; $display("[TB] FAIL wdog_tick7: got state %0d motor %0d expected 2/40", state_o, motor_cmd_o); end
    next_tick();
    total++; if (state_o !== 2'd3 || fault_o !== 1'b1 || armed_o !== 1'b0) begin bad++; $display("[TB] FAIL wdog_fault: got state %0d fault %0b armed %0b expected 3/1/0", state_o, fault_o, armed_o); end
    total++; if (motor_cmd_o !== 10'd0) begin bad++; $display("[TB] FAIL wdog_fault_motor: got %0d expected 0", motor_cmd_o); end
    fault_clear_i = 1'b1;
    clk(1);
    fault_clear_i = 1'b0;
    total++; if (state_o !== 2'd3) begin bad++; $display("[TB] FAIL clear_while_enabled: got %0d expected 3", state_o); end
    enable_i = 1'b0;
    clk(1);
    total++; if (state_o !== 2'd3) begin bad++; $display("[TB] FAIL fault_hold_no_clear: got %0d expected 3", state_o); end
    fault_clear_i = 1'b1;
    clk(1);
    fault_clear_i = 1'b0;
    total++; if (state_o !== 2'd0 || fault_o !== 1'b0) begin bad++; $display("[TB] FAIL clear_disabled: got state %0d fault %0b expected 0/0", state_o, fault_o); end
  endtask

  task automatic test_abort();
    enable_i = 1'b1;
    clk(1);
    for (int t = 0; t < 3; t++) next_tick();
    total++; if (state_o !== 2'd1) begin bad++; $display("[TB] FAIL abort_pre: got %0d expected 1", state_o); end
    enable_i = 1'b0;
    clk(1);
    total++; if (state_o !== 2'd0) begin bad++; $display("[TB] FAIL abort_disarm: got %0d expected 0", state_o); end
    enable_i = 1'b1;
    clk(1);
    total++; if (state_o !== 2'd1) begin bad++; $display("[TB] FAIL rearm_entry: got %0d expected 1", state_o); end
    for (int t = 0; t < 4; t++) next_tick();
    total++; if (state_o !== 2'd1 || armed_o !== 1'b0) begin bad++; $display("[TB] FAIL rearm_full_count: got state %0d armed %0b expected 1/0", state_o, armed_o); end
    next_tick();
    total++; if (state_o !== 2'd2 || armed_o !== 1'b1) begin bad++; $display("[TB] FAIL rearm_done: got state %0d armed %0b expected 2/1", state_o, armed_o); end
  endtask

  task automatic test_async_reset();
    send_cmd(10'd500);
    for (int t = 0; t < 3; t++) next_tick();
    total++; if (motor_cmd_o !== 10'd12) begin bad++; $display("[TB] FAIL midramp: got %0d expected 12", motor_cmd_o); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (motor_cmd_o !== 10'd0 || armed_o !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_out: got motor %0d armed %0b expected 0/0", motor_cmd_o, armed_o); end
    total++; if (state_o !== 2'd0 || fault_o !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_state: got state %0d fault %0b expected 0/0", state_o, fault_o); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    edges = 0;
    test_reset();
    test_arming();
    test_ramp();
    test_brake();
    test_watchdog();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
